// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-operation and controller-state definitions for the basic CPU.
package cpu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MV   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVI  = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    localparam logic [1:0] ALU_NOP = 2'd0;
    localparam logic [1:0] ALU_ADD = 2'd1;
    localparam logic [1:0] ALU_SUB = 2'd2;
    localparam logic [1:0] ALU_AND = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_T1   = ST_T1,
        S_T2   = ST_T2,
        S_T3   = ST_T3,
        S_FIN  = ST_FIN
    } state_t;

    function automatic logic [1:0] alu_of(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; output is all zero when disabled.
module onehot_dec #(
    parameter int W = 3
) (
    input  logic [W-1:0]      idx,
    input  logic              en,
    output logic [(2**W)-1:0] onehot
);

    localparam int N = 2 ** W;

    assign onehot = en ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/control_fsm.sv
// Instruction-sequencing controller: steps IDLE/T1/T2/T3/FIN and decodes IR into
// datapath strobes. Outputs are decoded from state and inputs, forced low in reset.
module control_fsm
    import cpu_pkg::*;
#(
    parameter int REG_SEL_W = 3
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      run,
    input  logic [3+2*REG_SEL_W-1:0]  IR,
    input  logic                      g_nz,
    output logic                      IRin,
    output logic                      DINout,
    output logic [REG_SEL_W-1:0]      Rout,
    output logic [(2**REG_SEL_W)-1:0] Rin,
    output logic                      Ain,
    output logic                      Gin,
    output logic                      Gout,
    output logic [1:0]                alu_op,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal
);

    localparam int IR_W = 3 + 2 * REG_SEL_W;

    state_t state;
    state_t next_state;
    logic   ill_flag;

    logic [2:0]           opcode;
    logic [REG_SEL_W-1:0] rx;
    logic [REG_SEL_W-1:0] ry;

    assign opcode = IR[IR_W-1 -: 3];
    assign rx     = IR[2*REG_SEL_W-1 -: REG_SEL_W];
    assign ry     = IR[REG_SEL_W-1:0];

    logic                 irin_c;
    logic                 dinout_c;
    logic [REG_SEL_W-1:0] rout_c;
    logic                 rin_en;
    logic                 ain_c;
    logic                 gin_c;
    logic                 gout_c;
    logic [1:0]           alu_c;
    logic                 done_c;
    logic                 illegal_c;

    always_comb begin
        next_state = state;
        irin_c     = 1'b0;
        dinout_c   = 1'b0;
        rout_c     = '0;
        rin_en     = 1'b0;
        ain_c      = 1'b0;
        gin_c      = 1'b0;
        gout_c     = 1'b0;
        alu_c      = ALU_NOP;
        done_c     = 1'b0;
        illegal_c  = 1'b0;

        case (state)
            S_IDLE: begin
                irin_c = run;
                if (run) next_state = S_T1;
            end
            S_T1: begin
                next_state = S_FIN;
                case (opcode)
                    OP_MV: begin
                        rout_c = ry;
                        rin_en = 1'b1;
                    end
                    OP_MVI: begin
                        dinout_c = 1'b1;
                        rin_en   = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (g_nz) begin
                            rout_c = ry;
                            rin_en = 1'b1;
                        end
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        rout_c     = rx;
                        ain_c      = 1'b1;
                        next_state = S_T2;
                    end
                    default: ;
                endcase
            end
            S_T2: begin
                rout_c     = ry;
                gin_c      = 1'b1;
                alu_c      = alu_of(opcode);
                next_state = S_T3;
            end
            S_T3: begin
                gout_c     = 1'b1;
                rin_en     = 1'b1;
                next_state = S_FIN;
            end
            S_FIN: begin
                done_c     = 1'b1;
                illegal_c  = ill_flag;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            ill_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_T1 && opcode == OP_ILL)
                ill_flag <= 1'b1;
            else if (state == S_FIN)
                ill_flag <= 1'b0;
        end
    end

    // Every strobe is qualified by resetn so outputs drop the instant reset asserts.
    onehot_dec #(.W(REG_SEL_W)) u_rin_dec (
        .idx    (rx),
        .en     (rin_en & resetn),
        .onehot (Rin)
    );

    assign IRin    = irin_c & resetn;
    assign DINout  = dinout_c & resetn;
    assign Rout    = resetn ? rout_c : '0;
    assign Ain     = ain_c & resetn;
    assign Gin     = gin_c & resetn;
    assign Gout    = gout_c & resetn;
    assign alu_op  = resetn ? alu_c : ALU_NOP;
    assign busy    = (state != S_IDLE) & resetn;
    assign done    = done_c & resetn;
    assign illegal = illegal_c & resetn;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm at REG_SEL_W=3 and REG_SEL_W=4: per-cycle vector table
// checked through an expectation queue, plus latency and issue-rate sequences.
module tb_control_fsm;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn;
    logic        g_nz;
    logic        run3, run4;
    logic [8:0]  ir3;
    logic [10:0] ir4;

    logic        irin3, din3, ain3, gin3, gout3, busy3, done3, ill3;
    logic [2:0]  rout3;
    logic [7:0]  rin3;
    logic [1:0]  alu3;

    logic        irin4, din4, ain4, gin4, gout4, busy4, done4, ill4;
    logic [3:0]  rout4;
    logic [15:0] rin4;
    logic [1:0]  alu4;

    control_fsm #(.REG_SEL_W(3)) dut3 (
        .clock(clock), .resetn(resetn), .run(run3), .IR(ir3), .g_nz(g_nz),
        .IRin(irin3), .DINout(din3), .Rout(rout3), .Rin(rin3),
        .Ain(ain3), .Gin(gin3), .Gout(gout3), .alu_op(alu3),
        .busy(busy3), .done(done3), .illegal(ill3)
    );

    control_fsm #(.REG_SEL_W(4)) dut4 (
        .clock(clock), .resetn(resetn), .run(run4), .IR(ir4), .g_nz(g_nz),
        .IRin(irin4), .DINout(din4), .Rout(rout4), .Rin(rin4),
        .Ain(ain4), .Gin(gin4), .Gout(gout4), .alu_op(alu4),
        .busy(busy4), .done(done4), .illegal(ill4)
    );

    // {irin, dinout, ain, gin, gout, alu[1:0], busy, done, illegal, rout[3:0], rin[15:0]}
    typedef logic [29:0] obs_t;

    typedef struct {
        string       name;
        bit          sel4;
        bit          rst;
        bit          run;
        logic [10:0] ir;
        bit          gnz;
        obs_t        exp;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t e(bit irin, bit din, bit ain, bit gin, bit gout,
                               logic [1:0] alu, bit busy, bit done, bit ill,
                               logic [3:0] rout, logic [15:0] rin);
        return {irin, din, ain, gin, gout, alu, busy, done, ill, rout, rin};
    endfunction

    function automatic logic [8:0] i3(logic [2:0] op, logic [2:0] rx, logic [2:0] y);
        return {op, rx, y};
    endfunction

    task automatic add_vec(string name, bit sel4, bit rst, bit run, logic [10:0] ir,
                           bit gnz, obs_t exp);
        vec_t v;
        v.name = name; v.sel4 = sel4; v.rst = rst; v.run = run;
        v.ir = ir; v.gnz = gnz; v.exp = exp;
        vecs.push_back(v);
    endtask

    function automatic obs_t observe(bit sel4);
        if (sel4)
            return {irin4, din4, ain4, gin4, gout4, alu4, busy4, done4, ill4, rout4, rin4};
        return {irin3, din3, ain3, gin3, gout3, alu3, busy3, done3, ill3,
                {1'b0, rout3}, {8'h00, rin3}};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam obs_t Z = '0;

    initial begin
        logic [8:0]  mv25, add16, mvnz40, mvi7, ill, sub33, nop, mv10;
        logic [10:0] and_f9;
        int lat, first, gap;
        bit seen;

        mv25   = i3(3'b001, 3'd2, 3'd5);
        add16  = i3(3'b010, 3'd1, 3'd6);
        mvnz40 = i3(3'b110, 3'd4, 3'd0);
        mvi7   = i3(3'b100, 3'd7, 3'd0);
        ill    = i3(3'b111, 3'd2, 3'd3);
        sub33  = i3(3'b011, 3'd3, 3'd3);
        nop    = i3(3'b000, 3'd5, 3'd6);
        mv10   = i3(3'b001, 3'd1, 3'd0);
        and_f9 = {3'b101, 4'hF, 4'h9};

        // reset held with run high, then mv R2,R5 (run also held through T1)
        add_vec("rst_run0", 0, 1, 1, 11'(mv25), 0, Z);
        add_vec("rst_run1", 0, 1, 1, 11'(mv25), 0, Z);
        add_vec("mv_idle",  0, 0, 1, 11'(mv25), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("mv_t1",    0, 0, 1, 11'(mv25), 0, e(0,0,0,0,0,0,1,0,0, 4'd5, 16'h0004));
        add_vec("mv_fin",   0, 0, 0, 11'(mv25), 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        add_vec("idle0",    0, 0, 0, 11'(mv25), 0, Z);
        // add R1,R6
        add_vec("add_idle", 0, 0, 1, 11'(add16), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("add_t1",   0, 0, 0, 11'(add16), 0, e(0,0,1,0,0,0,1,0,0, 4'd1, 16'h0));
        add_vec("add_t2",   0, 0, 0, 11'(add16), 0, e(0,0,0,1,0,1,1,0,0, 4'd6, 16'h0));
        add_vec("add_t3",   0, 0, 1, 11'(add16), 0, e(0,0,0,0,1,0,1,0,0, 4'd0, 16'h0002));
        add_vec("add_fin",  0, 0, 1, 11'(add16), 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        // mvnz R4,R0 with g_nz low then high (run held across the boundary)
        add_vec("mvnz0_idle", 0, 0, 1, 11'(mvnz40), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("mvnz0_t1",   0, 0, 0, 11'(mvnz40), 0, e(0,0,0,0,0,0,1,0,0, 4'd0, 16'h0));
        add_vec("mvnz0_fin",  0, 0, 0, 11'(mvnz40), 1, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        add_vec("mvnz1_idle", 0, 0, 1, 11'(mvnz40), 1, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("mvnz1_t1",   0, 0, 0, 11'(mvnz40), 1, e(0,0,0,0,0,0,1,0,0, 4'd0, 16'h0010));
        add_vec("mvnz1_fin",  0, 0, 0, 11'(mvnz40), 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        // mvi R7 then opcode 111
        add_vec("mvi_idle", 0, 0, 1, 11'(mvi7), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("mvi_t1",   0, 0, 0, 11'(mvi7), 0, e(0,1,0,0,0,0,1,0,0, 4'd0, 16'h0080));
        add_vec("mvi_fin",  0, 0, 0, 11'(mvi7), 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        add_vec("ill_idle", 0, 0, 1, 11'(ill), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("ill_t1",   0, 0, 0, 11'(ill), 1, e(0,0,0,0,0,0,1,0,0, 4'd0, 16'h0));
        add_vec("ill_fin",  0, 0, 0, 11'(ill), 0, e(0,0,0,0,0,0,1,1,1, 4'd0, 16'h0));
        add_vec("ill_after",0, 0, 0, 11'(ill), 0, Z);
        // illegal flag must not leak into the next instruction
        add_vec("mv10_idle",0, 0, 1, 11'(mv10), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("mv10_t1",  0, 0, 0, 11'(mv10), 0, e(0,0,0,0,0,0,1,0,0, 4'd0, 16'h0002));
        add_vec("mv10_fin", 0, 0, 0, 11'(mv10), 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        // sub R3,R3 aborted by reset in T2
        add_vec("sub_idle", 0, 0, 1, 11'(sub33), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("sub_t1",   0, 0, 0, 11'(sub33), 0, e(0,0,1,0,0,0,1,0,0, 4'd3, 16'h0));
        add_vec("sub_t2rst",0, 1, 1, 11'(sub33), 0, Z);
        add_vec("sub_rst2", 0, 1, 1, 11'(sub33), 0, Z);
        add_vec("post_rst0",0, 0, 0, 11'(sub33), 0, Z);
        add_vec("post_rst1",0, 0, 0, 11'(sub33), 0, Z);
        add_vec("nop_idle", 0, 0, 1, 11'(nop), 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
        add_vec("nop_t1",   0, 0, 0, 11'(nop), 0, e(0,0,0,0,0,0,1,0,0, 4'd0, 16'h0));
        add_vec("nop_fin",  0, 0, 0, 11'(nop), 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        // REG_SEL_W=4: and R15,R9 twice with run held high
        for (int k = 0; k < 2; k++) begin
            add_vec("and4_idle", 1, 0, 1, and_f9, 0, e(1,0,0,0,0,0,0,0,0, 4'd0, 16'h0));
            add_vec("and4_t1",   1, 0, 1, and_f9, 0, e(0,0,1,0,0,0,1,0,0, 4'd15, 16'h0));
            add_vec("and4_t2",   1, 0, 1, and_f9, 0, e(0,0,0,1,0,3,1,0,0, 4'd9, 16'h0));
            add_vec("and4_t3",   1, 0, 1, and_f9, 0, e(0,0,0,0,1,0,1,0,0, 4'd0, 16'h8000));
            add_vec("and4_fin",  1, 0, (k == 0), and_f9, 0, e(0,0,0,0,0,0,1,1,0, 4'd0, 16'h0));
        end
        add_vec("and4_idle_end", 1, 0, 0, and_f9, 0, Z);

        resetn = 1'b0; g_nz = 1'b0;
        run3 = 1'b0; run4 = 1'b0; ir3 = '0; ir4 = '0;

        foreach (vecs[i]) begin
            @(posedge clock); #1;
            resetn = ~vecs[i].rst;
            g_nz   = vecs[i].gnz;
            run3   = vecs[i].sel4 ? 1'b0 : vecs[i].run;
            run4   = vecs[i].sel4 ? vecs[i].run : 1'b0;
            ir3    = vecs[i].sel4 ? 9'd0 : vecs[i].ir[8:0];
            ir4    = vecs[i].sel4 ? vecs[i].ir : 11'd0;
            sb.push_back(vecs[i].exp);
            @(negedge clock);
            check(vecs[i].name, 32'(observe(vecs[i].sel4)), 32'(sb.pop_front()));
        end
        run3 = 1'b0; run4 = 1'b0;

        // add latency from the IDLE run cycle to done
        @(posedge clock); #1; ir3 = add16; run3 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1; run3 = 1'b0;
            if (done3) begin lat = k; break; end
        end
        check("add_latency", 32'(lat), 32'd4);

        // mvi latency
        @(posedge clock); #1; ir3 = mvi7; run3 = 1'b1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1; run3 = 1'b0;
            if (done3) begin lat = k; break; end
        end
        check("mvi_latency", 32'(lat), 32'd2);

        // done spacing with run held high, ALU op at width 4, and simple op at width 3
        @(posedge clock); #1; ir4 = and_f9; run4 = 1'b1;
        first = -1; gap = -1; seen = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            if (done4) begin
                if (!seen) begin first = k; seen = 1; end
                else begin gap = k - first; break; end
            end
        end
        run4 = 1'b0;
        check("and4_spacing", 32'(gap), 32'd5);

        @(posedge clock); #1; ir3 = mv25; run3 = 1'b1;
        first = -1; gap = -1; seen = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            if (done3) begin
                if (!seen) begin first = k; seen = 1; end
                else begin gap = k - first; break; end
            end
        end
        run3 = 1'b0;
        check("mv_spacing", 32'(gap), 32'd3);

        repeat (6) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Parametrised instruction-sequencing controller for the basic CPU datapath. It replaces the externally counted control decoder with its own step state machine, run/done handshake and instruction fetch strobe. It widens register selection through a parameter and adds four behaviours: move-immediate, bitwise AND, conditional move, and illegal-opcode flagging. It sits between the instruction register / DIN path and the register file, A/G registers, ALU and bus mux.

## Interface
- `REG_SEL_W`, default 3: register-select width.
  - Number of registers: N = 2**REG_SEL_W.
  - IR width: 3 + 2*REG_SEL_W.
- `clock`  in  1  sole clock; all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  start request, sampled in IDLE.
- `IR`  in  3+2*REG_SEL_W  instruction register contents.
  - opcode = `IR[MSB-:3]`.
  - Rx = next REG_SEL_W bits.
  - y = low REG_SEL_W bits.
- `g_nz`  in  1  G register is non-zero (from datapath).
- `IRin`  out  1  load IR from DIN.
- `DINout`  out  1  drive DIN onto the bus.
- `Rout`  out  REG_SEL_W  register index driven onto the bus.
- `Rin`  out  N  one-hot register write enable.
- `Ain`, `Gin`, `Gout`  out  1 each  A load, G load, and G drives bus.
- `alu_op`  out  2  ALU operation: NOP=0, ADD=1, SUB=2, AND=3.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse for opcode 111, coincident with `done`.

## Operation
- States: IDLE, T1, T2, T3, FIN. Encoded as a 3-bit register. Next state and outputs are combinational from state, IR, `run` and `g_nz`.
- Default value of every output is 0. `busy` = (state != IDLE).
- IDLE:
  - `IRin` = `run`.
  - If `run`=1, go to T1; otherwise stay in IDLE.
- T1, decoded by opcode:
  - 000 nop: no outputs asserted; go to FIN.
  - 001 mv: `Rout`=y, `Rin`=1<<Rx; go to FIN.
  - 100 mvi: `DINout`=1, `Rin`=1<<Rx (immediate must be on DIN this cycle); go to FIN.
  - 110 mvnz: if `g_nz`, `Rout`=y and `Rin`=1<<Rx; otherwise `Rin`=0. Go to FIN either way.
  - 010 add, 011 sub, 101 and: `Rout`=Rx, `Ain`=1; go to T2.
  - 111: no datapath strobes; go to FIN, latching an internal illegal flag.
  - Any other value: go to FIN.
- T2 (ALU ops only): `Rout`=y, `Gin`=1, `alu_op` = ADD, SUB or AND per opcode; go to T3.
- T3: `Gout`=1, `Rin`=1<<Rx; go to FIN.
- FIN:
  - `done`=1, and `illegal`=1 if the illegal flag is set.
  - Clear the flag and go to IDLE.
  - `run` is ignored in FIN and in all non-IDLE states. A new instruction starts only after a return to IDLE.
- IR must remain stable from T1 through FIN. The controller never re-reads IR mid-instruction except as a combinational decode.
- `Rin` is always exactly one-hot or zero. Rx = y is legal (e.g. add R3,R3 doubles R3).

## Timing
- Instruction latency, counted as cycles from the IDLE cycle with `run`=1 to `done` high:
  - nop, mv, mvi, mvnz, illegal: 2 cycles.
  - add, sub, and: 4 cycles.
- Back-to-back issue: `run` held high gives one instruction every 3 cycles (simple ops) or every 5 cycles (ALU ops). The extra cycle is the IDLE fetch.
- Reset:
  - `resetn`=0 forces state IDLE and clears the illegal flag immediately (asynchronous).
  - While reset is asserted, all outputs are 0, including `IRin`, regardless of `run`.
  - Reset mid-instruction aborts with no `done`.
  - The first `run` is sampled on the first rising edge after deassertion.
- `g_nz` is sampled only in T1 of mvnz.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: OP_NOP, OP_MV, OP_ADD, OP_SUB, OP_MVI, OP_AND, OP_MVNZ, OP_ILL.
  - ALU op constants: ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND.
  - state encoding localparams.
- One sub-module, `onehot_dec` (parameter W), generates `Rin` from Rx plus an enable. It is reusable by the register file.

## Test plan
- Reset with `run`=1 held → all outputs 0. Release reset and issue mv R2,R5 (REG_SEL_W=3) → T1: `Rout`=5, `Rin`=8'b0000_0100. `done` follows 1 cycle later.
- add R1,R6 → T1: `Rout`=1, `Ain`=1. T2: `Rout`=6, `Gin`=1, `alu_op`=1. T3: `Gout`=1, `Rin`=8'b0000_0010. `done` in cycle 4.
- mvnz R4,R0 twice: `g_nz`=0 → `Rin`=0 but `done` still pulses. `g_nz`=1 → `Rin`=8'b0001_0000, `Rout`=0.
- mvi R7 with DIN=0x1A5 → T1: `DINout`=1, `Rin`=8'b1000_0000. Opcode 111 → `illegal` and `done` both high in the same single cycle, with no strobes asserted.
- Assert `resetn`=0 during T2 of sub → outputs drop to 0 asynchronously, no `done`. After release, the FSM is in IDLE and waits for `run`.
- Rebuild with REG_SEL_W=4: and R15,R9 → `Rin`=16'h8000, `Rout`=9 in T2, `alu_op`=3. `run` held high → `done` every 5 cycles.
